cv32e40p_tmr_recovery_ctrl: RTL and testbench
=============================================

CV32E40P_TMR_RECOVERY_CTRL -- requirements
Module: cv32e40p_tmr_recovery_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the error event counter.
REQ-002 Parameter PERM_THRESH, default 3: consecutive recoveries blaming one lane before that lane is declared failed.
REQ-003 Parameter SETTLE_CYCLES, default 4: post-resync cycles during which voter errors are ignored.
REQ-004 Parameter HALT_TIMEOUT, default 64: maximum cycles spent waiting for the prefetcher to drain.
REQ-005 clk  in  1  clock; one clock domain, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 error_voter_i  in  5  per-voter mismatch flags from the TMR prefetch buffer.
REQ-008 lane_err_i  in  3  OR of per-replica outvoted flags (bit0=replica a, bit1=b, bit2=c).
REQ-009 busy_i  in  1  voted prefetcher busy.
REQ-010 resync_pc_i  in  32  PC at which fetch restarts after recovery.
REQ-011 clear_i  in  1  clears counter and sticky status.
REQ-012 halt_fetch_o  out  1  blocks new fetch requests while high.
REQ-013 resync_o  out  1  one-cycle branch pulse to all three replicas.
REQ-014 resync_addr_o  out  32  branch target, valid with resync_o.
REQ-015 err_count_o  out  CNT_WIDTH  saturating count of recovery events.
REQ-016 lane_fail_o  out  3  sticky permanent-fault flag per replica.
REQ-017 timeout_o  out  1  sticky: drain wait exceeded HALT_TIMEOUT.
REQ-018 recovering_o  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, HALT, RESYNC, SETTLE.
REQ-020 IDLE -> HALT when |error_voter_i; capture resync_pc_i and lane_err_i that cycle; otherwise stay.
REQ-021 HALT: halt_fetch_o=1; -> RESYNC on first cycle busy_i=0, or after HALT_TIMEOUT cycles in HALT (set timeout_o).
REQ-022 RESYNC: exactly one cycle; resync_o=1, resync_addr_o=captured PC, halt_fetch_o=1; -> SETTLE.
REQ-023 SETTLE: halt_fetch_o=0; error_voter_i ignored; -> IDLE after SETTLE_CYCLES cycles.
REQ-024 Error latency: error at cycle N with busy_i=0 gives resync_o at N+2.
REQ-025 err_count_o increments by 1 on each IDLE->HALT transition; saturates at all-ones, no wrap.
REQ-026 Per lane, 2-bit blame counter: increments on a recovery capturing that lane bit set, clears on a recovery with it clear; on reaching PERM_THRESH lane_fail_o bit sets and stays.
REQ-027 Errors arriving in HALT, RESYNC or SETTLE do not start a new recovery nor count.
REQ-028 Error in IDLE same cycle as clear_i: clear applies first, then count = 1.
REQ-029 clear_i zeroes err_count_o, blame counters, lane_fail_o, timeout_o; does not alter FSM state.
REQ-030 resync_addr_o = 0 when resync_o = 0.

Reset
REQ-031 rst asserted at any time, including mid-recovery: state IDLE, all outputs 0, counters 0, captured PC 0, asynchronously.
REQ-032 First error is recognised on the first clock edge after rst deasserts.

Configuration
REQ-033 Macro CV32E40P_TMR_RECOVERY_STATS_EN defined: err_count_o, blame counters and lane_fail_o implemented as specified.
REQ-034 Macro undefined: err_count_o and lane_fail_o tied to 0, blame counters absent; FSM, resync and timeout behaviour unchanged.

Structure
REQ-035 FSM state enum and default parameter constants live in the shared cv32e40p_pkg.
REQ-036 One sub-module, cv32e40p_tmr_lane_blame, instantiated three times, one per replica, holding the blame counter and sticky flag.

Verification
REQ-037 error_voter_i=5'b00010 one cycle, busy_i=0, resync_pc_i=0x0000_0080 -> resync_o at +2 cycles, resync_addr_o=0x80, err_count_o=1.
REQ-038 Error with busy_i held 1 for 10 cycles -> halt_fetch_o high 11 cycles, resync_o the cycle after busy_i falls.
REQ-039 busy_i stuck 1 -> resync_o after 64 HALT cycles, timeout_o=1.
REQ-040 Three consecutive recoveries with lane_err_i=3'b010 -> lane_fail_o=3'b010; a 3'b001 recovery between them -> lane_fail_o=0.
REQ-041 Error repeated during SETTLE -> no second recovery, err_count_o unchanged.
REQ-042 rst asserted in HALT -> halt_fetch_o=0 immediately; err_count_o=0; macro undefined -> err_count_o=0 after 5 recoveries.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types and default constants for the TMR prefetch recovery controller.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE   = 2'd0,
    TMR_HALT   = 2'd1,
    TMR_RESYNC = 2'd2,
    TMR_SETTLE = 2'd3
  } tmr_state_e;

  localparam int unsigned TMR_CNT_WIDTH     = 16;
  localparam int unsigned TMR_PERM_THRESH   = 3;
  localparam int unsigned TMR_SETTLE_CYCLES = 4;
  localparam int unsigned TMR_HALT_TIMEOUT  = 64;

  // Down-counters load (limit - 1), so clog2 of the larger limit is enough.
  function automatic int unsigned tmr_timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_recovery_ctrl_if.sv
// Prefetcher <-> recovery controller link: voter status in, fetch halt and resync branch out.
interface cv32e40p_tmr_recovery_ctrl_if;
  logic [4:0]  error_voter;
  logic [2:0]  lane_err;
  logic        busy;
  logic [31:0] resync_pc;
  logic        halt_fetch;
  logic        resync;
  logic [31:0] resync_addr;

  modport master (
    output error_voter, lane_err, busy, resync_pc,
    input  halt_fetch, resync, resync_addr
  );

  modport slave (
    input  error_voter, lane_err, busy, resync_pc,
    output halt_fetch, resync, resync_addr
  );
endinterface

// File: rtl/cv32e40p_tmr_lane_blame.sv
// Per-replica blame tracker: 2-bit count of consecutive recoveries blaming this lane, sticky fail flag.
module cv32e40p_tmr_lane_blame
  import cv32e40p_pkg::*;
#(
  parameter int unsigned PERM_THRESH = TMR_PERM_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic recover,
  input  logic blamed,
  output logic fail
);

  logic [1:0] cnt_q, cnt_base, cnt_d;
  logic       fail_base, fail_d;

  // Clear takes effect before a recovery landing in the same cycle.
  always_comb begin
    cnt_base  = clear ? 2'd0 : cnt_q;
    fail_base = clear ? 1'b0 : fail;
    cnt_d     = cnt_base;
    fail_d    = fail_base;
    if (recover) begin
      if (blamed) begin
        cnt_d = (cnt_base == 2'd3) ? cnt_base : cnt_base + 2'd1;
        if (({30'd0, cnt_base} + 32'd1) >= PERM_THRESH) begin
          fail_d = 1'b1;
        end
      end else begin
        cnt_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      fail  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fail  <= fail_d;
    end
  end

endmodule

// File: rtl/cv32e40p_tmr_recovery_ctrl.sv
// TMR prefetch recovery controller: halt, drain, resync all replicas, then settle.
// Statistics (err_count_o, lane blame, lane_fail_o) exist only with CV32E40P_TMR_RECOVERY_STATS_EN.
//
//   state      | meaning
//   TMR_IDLE   | watching voter flags; an error captures the PC and starts recovery
//   TMR_HALT   | fetch blocked, waiting for the prefetcher to drain (bounded)
//   TMR_RESYNC | single-cycle branch to the captured PC on all replicas
//   TMR_SETTLE | fetch resumes, voter flags masked while replicas reconverge
module cv32e40p_tmr_recovery_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = TMR_CNT_WIDTH,
  parameter int unsigned PERM_THRESH   = TMR_PERM_THRESH,
  parameter int unsigned SETTLE_CYCLES = TMR_SETTLE_CYCLES,
  parameter int unsigned HALT_TIMEOUT  = TMR_HALT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  cv32e40p_tmr_recovery_ctrl_if.slave    pf,
  input  logic                           clear_i,
  output logic [CNT_WIDTH-1:0]           err_count_o,
  output logic [2:0]                     lane_fail_o,
  output logic                           timeout_o,
  output logic                           recovering_o
);

  localparam int unsigned TMR_W = tmr_timer_width(HALT_TIMEOUT, SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] HALT_LOAD   = TMR_W'(HALT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  tmr_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [31:0]       pc_q;
  logic              start;
  logic              timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TMR_IDLE;
      tmr_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      if (start) begin
        pc_q <= pf.resync_pc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    start       = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      TMR_IDLE: begin
        if (|pf.error_voter) begin
          state_d = TMR_HALT;
          tmr_d   = HALT_LOAD;
          start   = 1'b1;
        end
      end
      TMR_HALT: begin
        if (!pf.busy) begin
          state_d = TMR_RESYNC;
        end else if (tmr_q == '0) begin
          state_d     = TMR_RESYNC;
          timeout_hit = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      TMR_RESYNC: begin
        state_d = TMR_SETTLE;
        tmr_d   = SETTLE_LOAD;
      end
      TMR_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = TMR_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  assign pf.halt_fetch  = (state_q == TMR_HALT) || (state_q == TMR_RESYNC);
  assign pf.resync      = (state_q == TMR_RESYNC);
  assign pf.resync_addr = pf.resync ? pc_q : 32'd0;
  assign recovering_o   = (state_q != TMR_IDLE);

  // A timeout in the same cycle as clear still leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_o <= 1'b0;
    end else if (timeout_hit) begin
      timeout_o <= 1'b1;
    end else if (clear_i) begin
      timeout_o <= 1'b0;
    end
  end

`ifdef CV32E40P_TMR_RECOVERY_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= start ? CNT_WIDTH'(1) : '0;
    end else if (start && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign err_count_o = cnt_q;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    cv32e40p_tmr_lane_blame #(
      .PERM_THRESH (PERM_THRESH)
    ) u_blame (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_i),
      .recover (start),
      .blamed  (pf.lane_err[g]),
      .fail    (lane_fail_o[g])
    );
  end
`else
  logic [2:0] unused_lane_err;
  logic [1:0] unused_perm_thresh;

  assign unused_lane_err    = pf.lane_err;
  assign unused_perm_thresh = 2'(PERM_THRESH);
  assign err_count_o        = '0;
  assign lane_fail_o        = 3'b000;
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_recovery_ctrl.sv
// Self-checking bench: vector table, directed corner sequences, and random traffic vs. a reference model.
module tb_cv32e40p_tmr_recovery_ctrl;

  localparam int CW = 4;
  localparam int HT = 64;
  localparam int ST = 4;
  localparam int PT = 3;
`ifdef CV32E40P_TMR_RECOVERY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [38+CW:0] out_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_i;
  logic [CW-1:0] err_count_o;
  logic [2:0]    lane_fail_o;
  logic          timeout_o;
  logic          recovering_o;

  int n_cmp = 0;
  int n_bad = 0;

  cv32e40p_tmr_recovery_ctrl_if bus ();

  cv32e40p_tmr_recovery_ctrl #(
    .CNT_WIDTH     (CW),
    .PERM_THRESH   (PT),
    .SETTLE_CYCLES (ST),
    .HALT_TIMEOUT  (HT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pf           (bus),
    .clear_i      (clear_i),
    .err_count_o  (err_count_o),
    .lane_fail_o  (lane_fail_o),
    .timeout_o    (timeout_o),
    .recovering_o (recovering_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  ev;
    logic [2:0]  le;
    logic        busy;
    logic [31:0] pc;
    logic        clr;
    logic        halt;
    logic        res;
    logic [31:0] addr;
    logic        rec;
    int          cnt;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mkv(input int ev, le, busy, pc, clr, h, r, a, rc, c);
    vec_t v;
    v.ev = 5'(ev); v.le = 3'(le); v.busy = 1'(busy); v.pc = 32'(pc); v.clr = 1'(clr);
    v.halt = 1'(h); v.res = 1'(r); v.addr = 32'(a); v.rec = 1'(rc); v.cnt = c;
    return v;
  endfunction

  function automatic out_t mk_out(input logic h, r, input logic [31:0] a, input logic rc, to,
                                  input int cnt, input logic [2:0] lf);
    logic [CW-1:0] c;
    logic [2:0]    l;
    c = STATS ? CW'(cnt) : {CW{1'b0}};
    l = STATS ? lf : 3'b000;
    return {h, r, a, rc, to, c, l};
  endfunction

  function automatic out_t dut_out();
    return {bus.halt_fetch, bus.resync, bus.resync_addr, recovering_o, timeout_o, err_count_o, lane_fail_o};
  endfunction

  task automatic chk(input string nm, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (halt,res,addr,rec,to,cnt,lane)", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] ev, input logic [2:0] le, input logic busy,
                       input logic [31:0] pc, input logic clr);
    bus.error_voter = ev;
    bus.lane_err    = le;
    bus.busy        = busy;
    bus.resync_pc   = pc;
    clear_i         = clr;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    drive(5'h0, 3'b0, 1'b0, 32'h0, 1'b0);
    while (recovering_o && n < 100) begin
      cyc();
      n++;
    end
    chk_int("idle_reached", int'(recovering_o), 0);
  endtask

  task automatic do_recovery(input logic [2:0] le, input logic [31:0] pc);
    drive(5'h01, le, 1'b0, pc, 1'b0);
    cyc();
    wait_idle();
  endtask

  task automatic clear_pulse();
    drive(5'h0, 3'b0, 1'b0, 32'h0, 1'b1);
    cyc();
    drive(5'h0, 3'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Reference model: recovery phase plus elapsed-cycle counters, applied per clock edge.
  int          m_phase;  // 0 watch, 1 drain, 2 branch, 3 quiet
  int          m_wait, m_quiet, m_count;
  int          m_blame[3];
  logic [31:0] m_pc;
  logic [2:0]  m_fail;
  logic        m_to;

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_quiet = 0; m_count = 0;
    m_blame = '{0, 0, 0}; m_pc = 32'h0; m_fail = 3'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [4:0] ev, input logic [2:0] le, input logic busy,
                            input logic [31:0] pc, input logic clr);
    if (clr) begin
      m_count = 0; m_blame = '{0, 0, 0}; m_fail = 3'b0; m_to = 1'b0;
    end
    case (m_phase)
      0: if (ev != 5'h0) begin
        m_phase = 1;
        m_wait  = 0;
        m_pc    = pc;
        if (m_count < (1 << CW) - 1) m_count++;
        for (int i = 0; i < 3; i++) begin
          if (le[i]) begin
            if (m_blame[i] < 3) m_blame[i]++;
            if (m_blame[i] >= PT) m_fail[i] = 1'b1;
          end else begin
            m_blame[i] = 0;
          end
        end
      end
      1: begin
        m_wait++;
        if (!busy) m_phase = 2;
        else if (m_wait == HT) begin
          m_phase = 2;
          m_to    = 1'b1;
        end
      end
      2: begin
        m_phase = 3;
        m_quiet = 0;
      end
      default: begin
        m_quiet++;
        if (m_quiet == ST) m_phase = 0;
      end
    endcase
  endtask

  function automatic out_t model_out();
    return mk_out(m_phase == 1 || m_phase == 2, m_phase == 2, (m_phase == 2) ? m_pc : 32'h0,
                  m_phase != 0, m_to, m_count, m_fail);
  endfunction

  initial begin
    int nh, res_at, guard, hold;
    logic bval;
    logic [4:0] rev;
    logic [2:0] rle;
    logic [31:0] rpc;
    logic rclr;

    tbl[0]  = mkv('h02, 0, 0, 'h80,   0, 1, 0, 0,     1, 1);
    tbl[1]  = mkv(0,    0, 0, 0,      0, 1, 1, 'h80,  1, 1);
    tbl[2]  = mkv('h02, 0, 0, 0,      0, 0, 0, 0,     1, 1);
    tbl[3]  = mkv('h1f, 0, 0, 0,      0, 0, 0, 0,     1, 1);
    tbl[4]  = mkv('h04, 0, 0, 0,      0, 0, 0, 0,     1, 1);
    tbl[5]  = mkv('h08, 0, 0, 0,      0, 0, 0, 0,     1, 1);
    tbl[6]  = mkv('h10, 0, 0, 'hdead, 0, 0, 0, 0,     0, 1);
    tbl[7]  = mkv('h01, 2, 0, 'h100,  0, 1, 0, 0,     1, 2);
    tbl[8]  = mkv(0,    0, 1, 0,      0, 1, 0, 0,     1, 2);
    tbl[9]  = mkv(0,    0, 0, 0,      0, 1, 1, 'h100, 1, 2);
    tbl[10] = mkv(0,    0, 0, 0,      1, 0, 0, 0,     1, 0);
    tbl[11] = mkv(0,    0, 0, 0,      0, 0, 0, 0,     1, 0);
    tbl[12] = mkv(0,    0, 0, 0,      0, 0, 0, 0,     1, 0);
    tbl[13] = mkv(0,    0, 0, 0,      0, 0, 0, 0,     1, 0);
    tbl[14] = mkv(0,    0, 0, 0,      0, 0, 0, 0,     0, 0);
    tbl[15] = mkv('h08, 0, 0, 'h200,  1, 1, 0, 0,     1, 1);
    tbl[16] = mkv(0,    0, 0, 0,      0, 1, 1, 'h200, 1, 1);

    drive(5'h0, 3'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("reset", dut_out(), '0);
    rst = 1'b0;

    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].ev, tbl[k].le, tbl[k].busy, tbl[k].pc, tbl[k].clr);
      cyc();
      chk($sformatf("vec%0d", k), dut_out(),
          mk_out(tbl[k].halt, tbl[k].res, tbl[k].addr, tbl[k].rec, 1'b0, tbl[k].cnt, 3'b000));
    end
    wait_idle();

    // Drain wait: busy high for the error cycle and nine more
    nh = 0;
    res_at = -1;
    for (int c = 0; c < 20; c++) begin
      drive((c == 0) ? 5'h04 : 5'h0, 3'b0, c < 10, 32'h40, 1'b0);
      cyc();
      if (bus.halt_fetch) nh++;
      if (bus.resync) res_at = c + 1;
    end
    chk_int("drain_halt_cycles", nh, 11);
    chk_int("drain_resync_cycle", res_at, 11);
    wait_idle();

    // Prefetcher never drains
    drive(5'h01, 3'b0, 1'b1, 32'h44, 1'b0);
    cyc();
    nh = 0;
    guard = 0;
    drive(5'h0, 3'b0, 1'b1, 32'h0, 1'b0);
    while (!bus.resync && guard < 200) begin
      if (bus.halt_fetch) nh++;
      cyc();
      guard++;
    end
    chk_int("timeout_resync_seen", int'(bus.resync), 1);
    chk_int("timeout_halt_cycles", nh, HT);
    chk_int("timeout_flag", int'(timeout_o), 1);
    chk_int("timeout_addr", int'(bus.resync_addr), 'h44);
    wait_idle();
    chk_int("timeout_sticky", int'(timeout_o), 1);
    clear_pulse();
    chk_int("timeout_cleared", int'(timeout_o), 0);

    // Lane blame
    for (int i = 0; i < 3; i++) do_recovery(3'b010, 32'h10);
    chk_int("lane_fail_3x", int'(lane_fail_o), STATS ? 2 : 0);
    clear_pulse();
    chk_int("lane_fail_clr", int'(lane_fail_o), 0);
    do_recovery(3'b010, 32'h10);
    do_recovery(3'b001, 32'h10);
    do_recovery(3'b010, 32'h10);
    chk_int("lane_fail_broken", int'(lane_fail_o), 0);
    do_recovery(3'b010, 32'h10);
    chk_int("lane_fail_2run", int'(lane_fail_o), 0);
    do_recovery(3'b010, 32'h10);
    chk_int("lane_fail_3run", int'(lane_fail_o), STATS ? 2 : 0);
    chk_int("count_after_5", int'(err_count_o), STATS ? 5 : 0);

    // Reset in the middle of a drain wait
    drive(5'h02, 3'b0, 1'b1, 32'h50, 1'b0);
    cyc();
    drive(5'h0, 3'b0, 1'b1, 32'h0, 1'b0);
    cyc();
    chk_int("pre_rst_halt", int'(bus.halt_fetch), 1);
    #2 rst = 1'b1;
    #1 chk("rst_async", dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;
    drive(5'h10, 3'b0, 1'b0, 32'h300, 1'b0);
    cyc();
    chk("post_rst_first", dut_out(), mk_out(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1, 3'b0));
    drive(5'h0, 3'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    chk("post_rst_resync", dut_out(), mk_out(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1, 3'b0));

    // Random traffic against the model
    rst = 1'b1;
    model_reset();
    drive(5'h0, 3'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    rst = 1'b0;
    hold = 0;
    bval = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      chk($sformatf("rand%0d", c), dut_out(), model_out());
      if ($urandom_range(0, 400) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1 chk("rand_rst", dut_out(), '0);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        if (hold == 0) begin
          bval = 1'($urandom_range(0, 1));
          hold = ($urandom_range(0, 15) == 0) ? int'($urandom_range(40, 90)) : int'($urandom_range(1, 4));
        end
        hold--;
        rev  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'h0;
        rle  = 3'($urandom);
        rpc  = $urandom;
        rclr = ($urandom_range(0, 60) == 0);
        drive(rev, rle, bval, rpc, rclr);
        model_step(rev, rle, bval, rpc, rclr);
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
